// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hcu_state_e;

    // Width of the mul/div down-counter for a given latency. The counter
    // holds at most latency-2, which always fits in clog2(latency) bits; the
    // floor of 1 keeps the vector legal when latency is 1 or 2.
    function automatic int md_cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

    localparam int MD_LATENCY_DEF = 4;
    localparam int MD_CNT_W       = md_cnt_width(MD_LATENCY_DEF);

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Purpose: free-running event counter, wraps modulo 2^CNT_W.
// Latency: count visible one cycle after the enabled cycle.
// Backpressure: none; counts every enabled cycle.
//
// Ports: clk_i, rst_i (async active-low), en (count this cycle), cnt (value).
module hazard_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Purpose: load-use stall, taken-branch flush and mul/div EX occupancy control.
// Latency: control outputs combinational (same cycle); state and counters registered.
// Backpressure: stalls the front end by dropping pc/ifid/idex write enables.
//
// Ports: hazard inputs from ID/EX, IF/ID and EX/MEM; write-enable, bubble and
// flush controls for PC, IF/ID, ID/EX, EX/MEM; md_ready_o; stall/flush counters.
module hazard_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             md_valid_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             idex_flush_o,
    output logic             exmem_bubble_o,
    output logic             exmem_flush_o,
    output logic             md_ready_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int CW = md_cnt_width(MD_LATENCY);
    // The first stall cycle happens in RUN, so MD_WAIT counts down from
    // latency-2 and spends one extra cycle at zero signalling ready.
    localparam logic [CW-1:0] MD_LOAD = CW'((MD_LATENCY > 1) ? MD_LATENCY - 2 : 0);

    hcu_state_e    state_q, state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          load_use;
    logic          stall_en, flush_en;

    assign load_use = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                      ((idex_rt_i == ifid_rs_i) ||
                       (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_bubble_o = 1'b0;
        exmem_flush_o  = 1'b0;
        md_ready_o     = 1'b0;

        if (!rst_i) begin
            // Hold the pipeline frozen and empty while reset is asserted.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            // Branch wins over everything, including an in-flight mul/div.
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            state_d       = RUN;
            md_cnt_d      = '0;
        end else if (state_q == MD_WAIT) begin
            if (md_cnt_q != '0) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_bubble_o = 1'b1;
                md_cnt_d       = md_cnt_q - CW'(1);
            end else begin
                md_ready_o = 1'b1;
                state_d    = RUN;
            end
        end else if (md_valid_i) begin
            if (MD_LATENCY > 1) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_bubble_o = 1'b1;
                md_cnt_d       = MD_LOAD;
                state_d        = MD_WAIT;
            end else begin
                md_ready_o = 1'b1;
            end
        end else if (load_use) begin
            // One bubble is enough: forwarding covers the load result next cycle.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    assign stall_en = rst_i && !pc_write_o;
    assign flush_en = rst_i && branch_taken_i;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (stall_en),
        .cnt   (stall_cnt_o)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (flush_en),
        .cnt   (flush_cnt_o)
    );

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline hazard scheduler for the 5-stage pipeline CPU. It sits beside the forwarding logic and handles the hazards forwarding cannot resolve:
- load-use stalls
- taken-branch flushes (branch resolved in MEM)
- multi-cycle mul/div occupancy of EX

It drives the write-enable, bubble and flush controls of the PC and the IF/ID, ID/EX and EX/MEM registers, and keeps stall/flush performance counters.

Parameters:
MD_LATENCY, 4, total EX-stage cycles for a mul/div instruction (>=1; 1 means no stall)
CNT_W, 16, width of the performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active low
idex_memread_i  in  1  instruction in ID/EX is a load
idex_rt_i  in  5  destination register of the load in ID/EX
ifid_rs_i  in  5  rs of the instruction in IF/ID
ifid_rt_i  in  5  rt of the instruction in IF/ID
ifid_uses_rt_i  in  1  IF/ID instruction reads rt as a source
md_valid_i  in  1  instruction in ID/EX is mul/div
branch_taken_i  in  1  branch in EX/MEM resolved taken
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  clear IF/ID to a NOP
idex_write_o  out  1  ID/EX load enable (0 = hold)
idex_bubble_o  out  1  zero the control fields loaded into ID/EX (load-use)
idex_flush_o  out  1  clear ID/EX (branch)
exmem_bubble_o  out  1  load zero control into EX/MEM (EX busy)
exmem_flush_o  out  1  clear EX/MEM (branch)
md_ready_o  out  1  mul/div result valid in EX this cycle
stall_cnt_o  out  CNT_W  count of cycles with pc_write_o=0 outside reset
flush_cnt_o  out  CNT_W  count of branch flush events

Behaviour:
- Reset: one clock; reset is asynchronous, active low (rst_i).
  - Reset values: state=RUN, md counter=0, stall_cnt_o=0, flush_cnt_o=0.
  - While rst_i=0, the control outputs are forced: pc_write_o=0, ifid_write_o=0, idex_write_o=0, all flush outputs=1, bubbles=0, md_ready_o=0.
- Default, no hazard: pc_write_o=1, ifid_write_o=1, idex_write_o=1, all bubble/flush outputs=0.
- Control outputs are combinational from state and inputs (same-cycle response). Only the state, md counter and perf counters are registered.
- Priority per cycle: branch > mul/div > load-use.
- Branch (any state, branch_taken_i=1):
  - ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1, pc_write_o=1 (loads the target).
  - Next state RUN, md counter cleared, flush_cnt_o+1.
  - In MD_WAIT the MEM stage holds a bubble, so a branch is not expected; if one arrives anyway it aborts the mul/div as above.
- Mul/div, state RUN, md_valid_i=1, MD_LATENCY>1:
  - pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_bubble_o=1.
  - Load counter with MD_LATENCY-2, go to MD_WAIT.
  - If MD_LATENCY=1: md_ready_o=1, no stall, stay RUN.
- State MD_WAIT:
  - counter!=0: same stall outputs; counter decrements.
  - counter==0: md_ready_o=1, no stall, go to RUN.
  - Net effect: exactly MD_LATENCY-1 stall cycles per mul/div.
  - A mul/div immediately following is seen fresh in RUN on the next cycle.
- Load-use (RUN, no higher-priority event):
  - Condition: idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || (ifid_uses_rt_i && idex_rt_i==ifid_rt_i)).
  - Response: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly that cycle.
  - No state change; forwarding covers the following cycle.
- stall_cnt_o increments on every cycle with pc_write_o=0 and rst_i=1. Both counters wrap modulo 2^CNT_W.
- Reset deasserted mid-MD_WAIT: restart in RUN; the instruction is re-evaluated if md_valid_i is still high.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding (RUN=1'b0, MD_WAIT=1'b1)
  - MD_CNT_W = clog2(MD_LATENCY)
  - the register-zero constant 5'd0
- One sub-module, hazard_perf_counter (CNT_W, enable, async active-low reset, wrapping), instantiated twice.

Test Plan:
- Load to rt=5 in ID/EX, IF/ID rs=5 -> exactly 1 cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o=1.
- Load to rt=0 with IF/ID rs=0; and load rt=7 with IF/ID rt=7 but ifid_uses_rt_i=0 -> no stall in either case.
- MD_LATENCY=4, md_valid_i held -> 3 stall cycles with exmem_bubble_o=1, md_ready_o=1 in the 4th cycle; back-to-back mul/div -> 6 stall cycles total.
- branch_taken_i coincident with load-use and md_valid_i -> all three flushes=1, pc_write_o=1, no stall, flush_cnt_o+1, state RUN.
- rst_i low during MD_WAIT (counter=1) -> outputs forced to reset values immediately; after release, state RUN and counters 0.
- CNT_W=4, 17 load-use stalls -> stall_cnt_o wraps to 1.
